// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
//   Shared definitions for the mux scan controller and its settle timer.
//
//   Contents:
//     ST_*            FSM state encodings (2-bit, legacy-compatible constants)
//     CNT_W           width of the settle down-counter (covers SETTLE 1..15)
//     is_busy_state   true for the states in which a scan is in progress
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Settle counter width; the largest reload value is SETTLE-1 = 14.
  localparam int CNT_W = 4;

  // busy is defined as "settling or sampling"; HOLD is not busy because the
  // word is complete and only waiting for the consumer.
  function automatic logic is_busy_state(input logic [1:0] st);
    return (st == ST_SETTLE) || (st == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/mux_settle_timer.sv
// ---------------------------------------------------------------------------
// mux_settle_timer
//   Loadable down-counter with a zero flag. The controller loads it with
//   SETTLE-1 whenever the mux select changes and lets it count down while
//   in the SETTLE state; the zero flag tells the FSM the settle window is
//   over.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset (count cleared)
//     load      load load_val into the counter (has priority over dec)
//     load_val  value to load
//     dec       decrement by one; saturates at zero
//     zero      count is zero (decoded from the count register)
// ---------------------------------------------------------------------------
module mux_settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      // Saturate at zero so a stray extra dec never wraps to 15.
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//   Scan controller wrapped around a 2**SEL_W : 1 mux. A single start pulse
//   walks the mux select through every channel, waits SETTLE cycles after
//   each select change, samples the mux output and packs the samples into a
//   parallel word that is handed over with a valid/ack handshake.
//
//   Parameters:
//     SEL_W   select width; channel count CH = 2**SEL_W
//     SETTLE  settle cycles after each select change (1..15)
//
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset; discards any partial scan
//     start    scan request, honoured in IDLE or in HOLD together with ack_i
//     y_i      mux output being captured
//     ack_i    consumer accepts data_o (only meaningful while valid_o=1)
//     sel_o    registered mux select
//     data_o   captured word; bit j = y_i sampled while sel_o=j
//     valid_o  data_o holds a completed scan
//     busy_o   scan in progress (SETTLE or SAMPLE)
//
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SEL_W  = 2,
  parameter int SETTLE = 1
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                y_i,
  input  logic                ack_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic [2**SEL_W-1:0] data_o,
  output logic                valid_o,
  output logic                busy_o
);

  localparam int CH = 2 ** SEL_W;

  // The settle counter is only 4 bits wide and a zero-length window would
  // need a different state sequence, so refuse to build outside 1..15.
  generate
    if ((SETTLE < 1) || (SETTLE > 15)) begin : g_bad_settle
      $error("mux_scan_ctrl: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(CH - 1);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [SEL_W-1:0] sel_reg;
  logic [SEL_W-1:0] sel_next;
  logic [CH-1:0]    capture_reg;
  logic [CH-1:0]    capture_sampled;
  logic [CH-1:0]    data_reg;
  logic [CH-1:0]    data_next;
  logic             valid_reg;
  logic             valid_next;
  logic             busy_reg;

  // Control strobes from the next-state logic
  logic             timer_load;
  logic             timer_zero;
  logic             capture_clear;
  logic             capture_en;

  // -------------------------------------------------------------------------
  // Settle timer
  // -------------------------------------------------------------------------
  mux_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (state_reg == ST_SETTLE),
    .zero     (timer_zero)
  );

  // -------------------------------------------------------------------------
  // Capture word as it would look after this cycle's sample: the bit
  // addressed by sel_reg takes y_i, the others keep their value. Used both
  // to update the capture register and, on the last channel, as the word
  // handed to data_o so the final sample does not need an extra cycle.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_capture
      assign capture_sampled[gi] = (sel_reg == SEL_W'(gi)) ? y_i : capture_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          capture_reg[gi] <= 1'b0;
        end else if (capture_clear) begin
          capture_reg[gi] <= 1'b0;
        end else if (capture_en) begin
          capture_reg[gi] <= capture_sampled[gi];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    data_next     = data_reg;
    valid_next    = valid_reg;
    timer_load    = 1'b0;
    capture_clear = 1'b0;
    capture_en    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_SETTLE;
          sel_next      = '0;
          capture_clear = 1'b1;
          timer_load    = 1'b1;
        end
      end

      ST_SETTLE: begin
        // Loaded with SETTLE-1 and left on zero, so this state lasts
        // exactly SETTLE cycles.
        if (timer_zero) begin
          state_next = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        capture_en = 1'b1;
        if (sel_reg == SEL_LAST) begin
          data_next  = capture_sampled;
          valid_next = 1'b1;
          state_next = ST_HOLD;
        end else begin
          sel_next   = sel_reg + SEL_W'(1);
          timer_load = 1'b1;
          state_next = ST_SETTLE;
        end
      end

      ST_HOLD: begin
        // Without ack the word is parked and start is deliberately dropped,
        // not queued.
        if (ack_i) begin
          valid_next = 1'b0;
          sel_next   = '0;
          if (start) begin
            state_next    = ST_SETTLE;
            capture_clear = 1'b1;
            timer_load    = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        sel_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      // Registered copy of "next state is busy" keeps busy_o aligned with
      // the state register without a decode after the flops.
      busy_reg  <= is_busy_state(state_next);
    end
  end

  assign sel_o   = sel_reg;
  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign busy_o  = busy_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
//   Two controller instances (SETTLE=1 and SETTLE=3), each closing the loop
//   through a behavioural 4:1 mux (y = mux_in[sel]). Stimulus pushes the
//   expected word into a per-instance queue; a monitor pops and compares on
//   every rising edge of valid_o.
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: defaults (SEL_W=2, SETTLE=1)
  logic [3:0] mux_in1 = 4'b0000;
  logic       start1 = 1'b0;
  logic       ack1 = 1'b0;
  logic       y1;
  logic [1:0] sel1;
  logic [3:0] data1;
  logic       valid1;
  logic       busy1;

  // Instance 3: SETTLE=3
  logic [3:0] mux_in3 = 4'b0000;
  logic       start3 = 1'b0;
  logic       ack3 = 1'b0;
  logic       y3;
  logic [1:0] sel3;
  logic [3:0] data3;
  logic       valid3;
  logic       busy3;

  // Behavioural stand-in for four_to_onemux
  assign y1 = mux_in1[sel1];
  assign y3 = mux_in3[sel3];

  mux_scan_ctrl #(.SEL_W(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_i(y1), .ack_i(ack1),
    .sel_o(sel1), .data_o(data1), .valid_o(valid1), .busy_o(busy1)
  );

  mux_scan_ctrl #(.SEL_W(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .y_i(y3), .ack_i(ack3),
    .sel_o(sel3), .data_o(data3), .valid_o(valid3), .busy_o(busy3)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q1[$];
  logic [3:0] exp_q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard monitors: compare on each rising edge of valid_o
  // -------------------------------------------------------------------------
  logic prev_v1 = 1'b0;
  logic prev_v3 = 1'b0;

  always @(negedge clk) begin
    if (valid1 && !prev_v1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: got data %0h, expected no result", data1);
      end else begin
        check("sb1_data", 32'(data1), 32'(exp_q1.pop_front()));
      end
    end
    prev_v1 <= valid1;
  end

  always @(negedge clk) begin
    if (valid3 && !prev_v3) begin
      if (exp_q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb3_unexpected: got data %0h, expected no result", data3);
      end else begin
        check("sb3_data", 32'(data3), 32'(exp_q3.pop_front()));
      end
    end
    prev_v3 <= valid3;
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for valid1 after the start edge (lat=0); records sel1 after each
  // of the first 8 edges, packed MSB-first, 2 bits per sample.
  task automatic wait_valid1(output int lat, output logic [15:0] seq);
    lat = 0;
    seq = {14'd0, sel1};
    while (!valid1 && lat < 40) begin
      tick();
      lat++;
      if (lat < 8) seq = {seq[13:0], sel1};
    end
  endtask

  // Full scan on instance 1 with ack afterwards.
  task automatic scan1(input logic [3:0] pat);
    int lat;
    logic [15:0] seq;
    mux_in1 = pat;
    start1 = 1'b1;
    exp_q1.push_back(pat);
    tick();
    start1 = 1'b0;
    check("busy_after_start", 32'(busy1), 32'd1);
    wait_valid1(lat, seq);
    check("latency_s1", 32'(lat), 32'd8);
    // sel after edges k..k+7: 0,0,1,1,2,2,3,3
    check("sel_sequence", 32'(seq), 32'h05AF);
    check("sel_last_in_hold", 32'(sel1), 32'd3);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("valid_drop_after_ack", 32'(valid1), 32'd0);
    check("data_kept_after_ack", 32'(data1), 32'(pat));
    check("sel_zero_after_ack", 32'(sel1), 32'd0);
    check("busy_idle_after_ack", 32'(busy1), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int lat;
    int n;
    logic [15:0] seq;
    logic stable;

    // Reset state
    tick();
    tick();
    check("rst_sel", 32'(sel1), 32'd0);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic scan and pattern sweep
    scan1(4'b1000);
    scan1(4'b0101);
    scan1(4'b1110);

    // Stall in HOLD, then back-to-back
    mux_in1 = 4'b0110;
    start1 = 1'b1;
    exp_q1.push_back(4'b0110);
    tick();
    start1 = 1'b0;
    wait_valid1(lat, seq);
    check("latency_stall_scan", 32'(lat), 32'd8);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ack1 = 1'b0;
      start1 = (i % 3 == 0);
      mux_in1 = ~mux_in1;
      tick();
      if (!(valid1 && data1 == 4'b0110 && !busy1 && sel1 == 2'd3)) stable = 1'b0;
    end
    start1 = 1'b0;
    check("stall_stable", 32'(stable), 32'd1);
    ack1 = 1'b1;
    start1 = 1'b1;
    mux_in1 = 4'b1001;
    exp_q1.push_back(4'b1001);
    tick();
    ack1 = 1'b0;
    start1 = 1'b0;
    check("b2b_busy", 32'(busy1), 32'd1);
    check("b2b_valid_low", 32'(valid1), 32'd0);
    check("b2b_sel_zero", 32'(sel1), 32'd0);
    wait_valid1(lat, seq);
    check("b2b_latency", 32'(lat), 32'd8);
    check("b2b_sel_sequence", 32'(seq), 32'h05AF);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;

    // Asynchronous reset mid-scan (no result expected from this scan)
    mux_in1 = 4'b1111;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (sel1 != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    check("reached_sel2", 32'(sel1), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel1), 32'd0);
    check("arst_data", 32'(data1), 32'd0);
    check("arst_valid", 32'(valid1), 32'd0);
    check("arst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle_busy", 32'(busy1), 32'd0);
    scan1(4'b0011);

    // SETTLE=3: input changes inside channel 1's settle window
    mux_in3 = 4'b1010;
    start3 = 1'b1;
    // bit0 from 1010 (0), bits1..3 from 0101 (0,1,0)
    exp_q3.push_back(4'b0100);
    tick();
    start3 = 1'b0;
    lat = 0;
    while (!valid3 && lat < 60) begin
      tick();
      lat++;
      if (lat == 5) begin
        check("s3_sel_in_window", 32'(sel3), 32'd1);
        mux_in3 = 4'b0101;
      end
    end
    check("latency_s3", 32'(lat), 32'd16);
    ack3 = 1'b1;
    tick();
    ack3 = 1'b0;
    check("s3_valid_drop", 32'(valid3), 32'd0);

    tick();
    tick();
    check("sb1_drained", 32'(exp_q1.size()), 32'd0);
    check("sb3_drained", 32'(exp_q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Scan controller placed directly around the 4:1 mux stage (four_to_onemux).
- Upstream: drives the mux select lines through every channel in turn.
- Downstream: samples the mux output y after a programmable settle time and packs the samples into a parallel word.
- Hands the completed word to the consumer with a valid/ack handshake. This gives a one-shot "read all mux inputs" operation from a single start pulse.

Parameters:
SEL_W, 2, select width; channel count CH = 2**SEL_W (4 by default).
SETTLE, 1, clock cycles to wait after a select change before sampling y_i; legal range is 1..15; elaboration must fail outside this range.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a scan; sampled only when the block can accept it.
y_i  input  1  mux output being captured.
ack_i  input  1  consumer accepts data_o; meaningful only while valid_o=1.
sel_o  output  SEL_W  mux select; registered.
data_o  output  CH  captured word; bit j = y_i sampled while sel_o=j.
valid_o  output  1  data_o holds a completed scan.
busy_o  output  1  a scan is in progress (states SETTLE or SAMPLE).

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state=IDLE; sel_o=0; data_o=0; valid_o=0; busy_o=0.
  - Settle counter and capture register cleared.
  - Any partial scan is discarded.
- States: IDLE, SETTLE, SAMPLE, HOLD. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> SETTLE with sel_o=0, capture register cleared, settle counter loaded with SETTLE-1.
  - Otherwise stay in IDLE.
- SETTLE:
  - Counter decrements each cycle.
  - At count 0 -> SAMPLE.
  - The state therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - capture[sel_o] <= y_i.
  - If sel_o==CH-1: data_o <= capture with bit CH-1 set to y_i; valid_o <= 1; -> HOLD.
  - Else: sel_o <= sel_o+1; counter reloaded; -> SETTLE.
- HOLD:
  - valid_o=1; data_o stable; sel_o stays at CH-1.
  - ack_i=1 and start=0 -> IDLE; valid_o <= 0; sel_o <= 0.
  - ack_i=1 and start=1 -> back-to-back scan: SETTLE directly, sel_o=0, valid_o <= 0.
  - ack_i=0: hold indefinitely; start is ignored.
- busy_o=1 exactly in SETTLE and SAMPLE.
- Latency:
  - If start is sampled at edge k, channel j is sampled at edge k+(j+1)*(SETTLE+1).
  - valid_o rises after edge k+CH*(SETTLE+1). With defaults this is 8 cycles.
- Ignored inputs:
  - start while busy_o=1 or in HOLD without ack_i: ignored, not queued.
  - ack_i while valid_o=0: ignored.
- Stability:
  - data_o changes only on SAMPLE of the last channel, or on reset.
  - data_o keeps its last value after ack until the next scan completes.
- Select ordering: sel_o increments by 1 only and never wraps mid-scan. Return to 0 happens only on scan start, ack, or reset.

Decomposition:
- Shared package mux_scan_pkg:
  - State encoding localparams (ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_SAMPLE=2'd2, ST_HOLD=2'd3).
  - SETTLE counter width constant (4 bits).
- One sub-module is natural: mux_settle_timer, a loadable down-counter with a zero flag. It is instantiated once.
- The FSM, select counter and capture register stay in the top module.

Test Plan:
- Bench instantiates four_to_onemux with its select driven by sel_o and its output feeding y_i.
- Basic scan: i=4'b1000, pulse start -> valid_o after 8 cycles; data_o=4'b1000; sel_o sequence 0,1,2,3.
- Pattern sweep: i=4'b0101 then 4'b1110, each scan acked -> data_o=4'b0101, then 4'b1110; valid_o drops the cycle after ack.
- Stall and back-to-back:
  - Hold ack_i=0 for 20 cycles -> data_o/valid_o stable; start pulses ignored.
  - Then ack_i=1 together with start=1 -> busy_o=1 next cycle; second result arrives 8 cycles later.
- Reset mid-scan: assert rst_n=0 while sel_o=2 -> outputs immediately 0, asynchronous with no clock edge needed. After release, a fresh scan with i=4'b0011 -> data_o=4'b0011.
- SETTLE=3: change i during the settle window of channel 1 -> the sampled value is the one present at the sample edge; valid_o at 16 cycles.
